// File: rtl/pc_unit_if.sv
// Fetch-stage PC unit bus: redirect, RAS and stall controls in; PC, prediction and status out.
// Every request input is a single-cycle valid strobe sampled at the rising clock edge; there is no ready, since the unit accepts each request, and stall/redirect only suppress RAS operations.
interface pc_unit_if #(parameter int WIDTH = 32);
  logic             stall;
  logic             redirect;
  logic [1:0]       redirect_mode;
  logic [WIDTH-1:0] redirect_base;
  logic [WIDTH-1:0] ImmOp;
  logic             ras_push;
  logic [WIDTH-1:0] ras_push_addr;
  logic             ras_pop;
  logic [WIDTH-1:0] PC;
  logic [WIDTH-1:0] next_PC;
  logic             misaligned;
  logic             ras_empty;
  logic             ras_full;

  modport master (
    output stall, redirect, redirect_mode, redirect_base, ImmOp,
           ras_push, ras_push_addr, ras_pop,
    input  PC, next_PC, misaligned, ras_empty, ras_full
  );

  modport slave (
    input  stall, redirect, redirect_mode, redirect_base, ImmOp,
           ras_push, ras_push_addr, ras_pop,
    output PC, next_PC, misaligned, ras_empty, ras_full
  );
endinterface

// File: rtl/pc_unit.sv
// Program-counter register with next-PC selection (redirect > stall > RAS prediction > increment)
// and a circular return-address stack.
module pc_unit #(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter logic [WIDTH-1:0] TRAP_VECTOR  = 'h100,
  parameter int               INC          = 4,
  parameter int               RAS_DEPTH    = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  pc_unit_if.slave bus
);
  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [1:0] MODE_JALR = 2'b01;
  localparam logic [1:0] MODE_TRAP = 2'b10;

  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] next_pc;
  logic [WIDTH-1:0] target;
  logic [WIDTH-1:0] ras_top;
  logic             mis_q;
  logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
  logic [PW-1:0]    ptr_q;
  logic [CW-1:0]    cnt_q;
  logic             empty;
  logic             full;
  logic             trap;
  logic             ras_en;
  logic             do_push;
  logic             do_pop;
  logic             do_replace;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CW'(RAS_DEPTH));
  assign ras_top = ras_mem[ptr_q];

  always_comb begin
    target     = bus.redirect_base + bus.ImmOp;
    trap       = bus.redirect && (bus.redirect_mode == MODE_TRAP);
    ras_en     = !bus.stall && !bus.redirect;
    // Push and pop together on a non-empty stack is a tail call: swap the top in place.
    do_replace = ras_en && bus.ras_push && bus.ras_pop && !empty;
    do_push    = ras_en && bus.ras_push && !do_replace;
    do_pop     = ras_en && bus.ras_pop && !bus.ras_push && !empty;

    next_pc = pc_q + WIDTH'(INC);
    if (bus.redirect) begin
      case (bus.redirect_mode)
        MODE_JALR: next_pc = {target[WIDTH-1:1], 1'b0};
        MODE_TRAP: next_pc = TRAP_VECTOR;
        default:   next_pc = target;
      endcase
    end else if (bus.stall) begin
      next_pc = pc_q;
    end else if (bus.ras_pop && !empty) begin
      next_pc = ras_top;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q  <= RESET_VECTOR;
      mis_q <= 1'b0;
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      pc_q <= next_pc;

      if (bus.redirect) begin
        mis_q <= !trap && (next_pc[1:0] != 2'b00);
      end else if (!bus.stall) begin
        mis_q <= 1'b0;
      end

      if (trap) begin
        cnt_q <= '0;
      end else if (do_push) begin
        ptr_q <= ptr_q + 1'b1;
        if (!full) cnt_q <= cnt_q + 1'b1;
      end else if (do_pop) begin
        ptr_q <= ptr_q - 1'b1;
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

  // Entry storage has no reset; only count/ptr define which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) begin
      ras_mem[ptr_q + 1'b1] <= bus.ras_push_addr;
    end else if (do_replace) begin
      ras_mem[ptr_q] <= bus.ras_push_addr;
    end
  end

  assign bus.PC         = pc_q;
  assign bus.next_PC    = next_pc;
  assign bus.misaligned = mis_q;
  assign bus.ras_empty  = empty;
  assign bus.ras_full   = full;
endmodule
